// File: rtl/control_acc.sv
`timescale 1ns/1ps
// Multi-cycle sequencer for a single-accumulator machine: fetches, decodes and
// drives Moore strobes for the accumulator datapath and data memory.
module control_acc #(
    parameter int PB = 11,
    parameter int DB = 5 + PB
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [DB-1:0] Instr,
    output logic [PB-1:0] PCAddr,
    output logic [PB-1:0] DataAddr,
    output logic [DB-1:0] Imm,
    output logic          SelIn,
    output logic          Neg,
    output logic          ClrAcc,
    output logic          WrAcc,
    output logic          RdRam,
    output logic          WrRam,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [15:0]   InstrCount
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_CLEAR,
        S_MEMRD,
        S_EXEC,
        S_HALT
    } state_t;

    state_t               state;
    logic [PB-1:0]        pc;
    logic [DB-1:0]        ir;
    logic [15:0]          icnt;
    logic [4:0]           instr_op;
    logic [4:0]           ir_op;
    logic signed [PB-1:0] operand;
    logic signed [DB-1:0] imm_ext;

    assign instr_op   = Instr[DB-1:DB-5];
    assign ir_op      = ir[DB-1:DB-5];
    assign operand    = ir[PB-1:0];
    assign imm_ext    = DB'(operand);
    assign Imm        = imm_ext;
    assign PCAddr     = pc;
    assign DataAddr   = ir[PB-1:0];
    assign InstrCount = icnt;

    // EXEC-cycle controls for an opcode, packed as {WrRam, WrAcc, SelIn, Neg}.
    function automatic logic [3:0] exec_ctrl(input logic [4:0] op);
        case (op)
            OP_STO:  exec_ctrl = 4'b1000;
            OP_LD:   exec_ctrl = 4'b0100;
            OP_LDI:  exec_ctrl = 4'b0110;
            OP_ADD:  exec_ctrl = 4'b0100;
            OP_ADDI: exec_ctrl = 4'b0110;
            OP_SUB:  exec_ctrl = 4'b0101;
            OP_SUBI: exec_ctrl = 4'b0111;
            default: exec_ctrl = 4'b0000;
        endcase
    endfunction

    // Outputs are registered on entry to the state that owns them, so each
    // strobe is high for exactly the one cycle spent in that state.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            icnt   <= '0;
            Error  <= 1'b0;
            Busy   <= 1'b0;
            Halted <= 1'b0;
            ClrAcc <= 1'b0;
            WrAcc  <= 1'b0;
            RdRam  <= 1'b0;
            WrRam  <= 1'b0;
            SelIn  <= 1'b0;
            Neg    <= 1'b0;
        end else begin
            ClrAcc <= 1'b0;
            WrAcc  <= 1'b0;
            RdRam  <= 1'b0;
            WrRam  <= 1'b0;
            SelIn  <= 1'b0;
            Neg    <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        icnt   <= '0;
                        Error  <= 1'b0;
                        Busy   <= 1'b1;
                        Halted <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir <= Instr;
                    case (instr_op)
                        OP_HLT: begin
                            state  <= S_HALT;
                            Busy   <= 1'b0;
                            Halted <= 1'b1;
                        end
                        OP_LD, OP_LDI: begin
                            state  <= S_CLEAR;
                            ClrAcc <= 1'b1;
                            RdRam  <= (instr_op == OP_LD);
                        end
                        OP_ADD, OP_SUB: begin
                            state <= S_MEMRD;
                            RdRam <= 1'b1;
                        end
                        OP_STO, OP_ADDI, OP_SUBI: begin
                            state <= S_EXEC;
                            {WrRam, WrAcc, SelIn, Neg} <= exec_ctrl(instr_op);
                        end
                        default: begin
                            state  <= S_HALT;
                            Busy   <= 1'b0;
                            Halted <= 1'b1;
                            Error  <= 1'b1;
                        end
                    endcase
                end
                S_CLEAR, S_MEMRD: begin
                    state <= S_EXEC;
                    {WrRam, WrAcc, SelIn, Neg} <= exec_ctrl(ir_op);
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc + PB'(1);
                    icnt  <= icnt + 16'd1;
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
